// File: rtl/acc_cpu_if.sv
// Interface between the TT pin wrapper and the accumulator CPU.
// The master side drives program load and run control; the slave side reports CPU state.
interface acc_cpu_if #(
    parameter int DW = 4,
    parameter int AW = 4
);
    localparam int IW = 4 + DW;

    logic          run;
    logic          step_en;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic          flag_z;
    logic          flag_c;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;

    modport master (
        output run, step_en, ld_we, ld_addr, ld_data,
        input  acc, pc, flag_z, flag_c, out_data, out_valid, halted
    );

    modport slave (
        input  run, step_en, ld_we, ld_addr, ld_data,
        output acc, pc, flag_z, flag_c, out_data, out_valid, halted
    );
endinterface

// File: rtl/tt_um_acc_cpu_gen.sv
// Parametrised accumulator CPU with a writable program RAM.
// It has three modes: LOAD, RUN and HALT.
module tt_um_acc_cpu_gen #(
    parameter int DW        = 4,
    parameter int AW        = 4,
    parameter int LAST_ADDR = 5
) (
    input logic       clk,
    input logic       rst_n,
    acc_cpu_if.slave  bus
);
    localparam int IW    = 4 + DW;
    localparam int DEPTH = 1 << AW;

    if (AW > DW) begin : g_bad_aw
        $error("tt_um_acc_cpu_gen: AW must not exceed DW");
    end

    localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6,
                           OP_JMP = 4'h7, OP_JZ  = 4'h8, OP_JC  = 4'h9,
                           OP_OUT = 4'hA, OP_ADC = 4'hB, OP_HLT = 4'hF;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          z_q, z_d, c_q, c_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [IW-1:0] prog_mem [DEPTH];
    logic          prog_we;
    logic [IW-1:0] instr;
    logic [3:0]    op;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc_inc;
    logic [DW:0]   sum;
    logic          upd_z;

    assign instr  = prog_mem[pc_q];
    assign op     = instr[IW-1 -: 4];
    assign imm    = instr[DW-1:0];
    assign pc_inc = (pc_q == AW'(LAST_ADDR) || pc_q == '1) ? '0 : pc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pc_d        = pc_q;
        z_d         = z_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        prog_we     = 1'b0;
        sum         = '0;
        upd_z       = 1'b0;

        if (!bus.run) begin
            // run low always wins: back to LOAD with a clean machine state
            state_d = S_LOAD;
            acc_d   = '0;
            pc_d    = '0;
            z_d     = 1'b0;
            c_d     = 1'b0;
            prog_we = (state_q == S_LOAD) && bus.ld_we;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    prog_we = bus.ld_we;
                    state_d = S_RUN;
                end
                S_RUN: if (bus.step_en) begin
                    pc_d = pc_inc;
                    case (op)
                        OP_LDI: begin acc_d = imm; upd_z = 1'b1; end
                        OP_ADD, OP_ADC: begin
                            sum   = {1'b0, acc_q} + {1'b0, imm}
                                  + {{DW{1'b0}}, (op == OP_ADC) & c_q};
                            acc_d = sum[DW-1:0];
                            c_d   = sum[DW];
                            upd_z = 1'b1;
                        end
                        OP_SUB: begin
                            acc_d = acc_q - imm;
                            c_d   = acc_q < imm;
                            upd_z = 1'b1;
                        end
                        OP_AND: begin acc_d = acc_q & imm; c_d = 1'b0; upd_z = 1'b1; end
                        OP_OR:  begin acc_d = acc_q | imm; c_d = 1'b0; upd_z = 1'b1; end
                        OP_XOR: begin acc_d = acc_q ^ imm; c_d = 1'b0; upd_z = 1'b1; end
                        OP_JMP: pc_d = imm[AW-1:0];
                        OP_JZ:  if (z_q) pc_d = imm[AW-1:0];
                        OP_JC:  if (c_q) pc_d = imm[AW-1:0];
                        OP_OUT: begin out_data_d = acc_q; out_valid_d = 1'b1; end
                        OP_HLT: begin pc_d = pc_q; state_d = S_HALT; end
                        default: ;
                    endcase
                    if (upd_z) z_d = (acc_d == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            acc_q       <= '0;
            pc_q        <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pc_q        <= pc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Program RAM deliberately has no reset so a program survives rst_n pulses
    always_ff @(posedge clk) begin
        if (prog_we) prog_mem[bus.ld_addr] <= bus.ld_data;
    end

    assign bus.acc       = acc_q;
    assign bus.pc        = pc_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_tt_um_acc_cpu_gen.sv
// Scoreboard bench for tt_um_acc_cpu_gen: stimulus queues expected snapshots and OUT values,
// and a negedge monitor pops and compares them.
module tb_tt_um_acc_cpu_gen;
    localparam int DW = 4, AW = 4, LAST = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    acc_cpu_if #(.DW(DW), .AW(AW)) bus ();
    tt_um_acc_cpu_gen #(.DW(DW), .AW(AW), .LAST_ADDR(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        string    name;
        int       acc, pc, z, c, h, od;
    } snap_t;

    int         checks = 0, failures = 0;
    snap_t      st_q[$];
    int         out_q[$];
    bit         probe = 1'b0;
    snap_t      s;
    int         e;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (out_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL out_valid: got unexpected pulse with out_data %0d expected none", bus.out_data);
            end else begin
                e = out_q.pop_front();
                chk("out_pulse_data", int'(bus.out_data), e);
            end
        end
        if (probe && st_q.size() > 0) begin
            s = st_q.pop_front();
            chk({s.name, ".acc"},    int'(bus.acc),    s.acc);
            chk({s.name, ".pc"},     int'(bus.pc),     s.pc);
            chk({s.name, ".z"},      int'(bus.flag_z), s.z);
            chk({s.name, ".c"},      int'(bus.flag_c), s.c);
            chk({s.name, ".halted"}, int'(bus.halted), s.h);
            chk({s.name, ".out"},    int'(bus.out_data), s.od);
        end
    end

    function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] imm);
        return {op, imm};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic expect_st(input string nm, input int a, input int p, input int z,
                             input int c, input int h, input int od);
        snap_t t;
        t.name = nm; t.acc = a; t.pc = p; t.z = z; t.c = c; t.h = h; t.od = od;
        st_q.push_back(t);
        probe = 1'b1;
        @(negedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic go_load();
        bus.run = 1'b0;
        tick();
    endtask

    task automatic load(input int addr, input logic [7:0] w);
        bus.ld_we   = 1'b1;
        bus.ld_addr = addr[AW-1:0];
        bus.ld_data = w;
        tick();
        bus.ld_we   = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0; bus.step_en = 1'b0; bus.ld_we = 1'b0;
        bus.ld_addr = '0; bus.ld_data = '0;
        rst_n = 1'b0;
        tick(); tick();
        expect_st("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // 1: LDI 3, ADD 4, OUT, HLT
        load(0, ins(4'h1, 4'd3)); load(1, ins(4'h2, 4'd4));
        load(2, ins(4'hA, 4'd0)); load(3, ins(4'hF, 4'd0));
        out_q.push_back(7);
        bus.run = 1'b1; bus.step_en = 1'b1;
        repeat (6) tick();
        expect_st("t1_halt", 7, 3, 0, 0, 1, 7);

        // 2: carry chain and logic ops
        go_load();
        expect_st("t2_enter_load", 0, 0, 0, 0, 0, 7);
        load(0, ins(4'h1, 4'd9)); load(1, ins(4'h2, 4'd9)); load(2, ins(4'hB, 4'd0));
        load(3, ins(4'h6, 4'd3)); load(4, ins(4'h5, 4'd5)); load(5, ins(4'hF, 4'd0));
        bus.run = 1'b1;
        tick(); tick(); tick();
        expect_st("t2_add", 2, 2, 0, 1, 0, 7);
        tick(); expect_st("t2_adc", 3, 3, 0, 0, 0, 7);
        tick(); expect_st("t2_xor", 0, 4, 1, 0, 0, 7);
        tick(); expect_st("t2_or",  5, 5, 0, 0, 0, 7);
        tick(); expect_st("t2_hlt", 5, 5, 0, 0, 1, 7);

        // 3: SUB to zero, JZ taken; borrow, JZ untaken, JC taken, OUT
        go_load();
        load(0, ins(4'h1, 4'd5)); load(1, ins(4'h3, 4'd5)); load(2, ins(4'h8, 4'd0));
        bus.run = 1'b1;
        tick(); tick(); tick();
        expect_st("t3_sub", 0, 2, 1, 0, 0, 7);
        tick(); expect_st("t3_jz", 0, 0, 1, 0, 0, 7);
        go_load();
        load(0, ins(4'h3, 4'd1)); load(1, ins(4'h8, 4'd5)); load(2, ins(4'h9, 4'd4));
        load(3, ins(4'h0, 4'd0)); load(4, ins(4'hA, 4'd0)); load(5, ins(4'hF, 4'd0));
        out_q.push_back(15);
        bus.run = 1'b1;
        tick(); tick();
        expect_st("t3_borrow", 15, 1, 0, 1, 0, 7);
        tick(); expect_st("t3_jz_nt", 15, 2, 0, 1, 0, 7);
        tick(); expect_st("t3_jc",    15, 4, 0, 1, 0, 7);
        tick(); expect_st("t3_out",   15, 5, 0, 1, 0, 15);
        tick(); expect_st("t3_hlt",   15, 5, 0, 1, 1, 15);

        // 4: PC wrap at LAST_ADDR, then jump above it and wrap at 2^AW-1
        go_load();
        for (int i = 0; i < 6; i++) load(i, ins(4'h0, 4'd0));
        bus.run = 1'b1;
        tick();
        expect_st("t4_pc0", 0, 0, 0, 0, 0, 15);
        for (int i = 1; i <= 6; i++) begin
            tick();
            expect_st($sformatf("t4_seq%0d", i), 0, i % 6, 0, 0, 0, 15);
        end
        go_load();
        load(0, ins(4'h7, 4'd12));
        for (int i = 12; i < 16; i++) load(i, ins(4'hC, 4'd0));
        bus.run = 1'b1;
        tick(); tick();
        expect_st("t4_jmp", 0, 12, 0, 0, 0, 15);
        for (int i = 13; i <= 16; i++) begin
            tick();
            expect_st($sformatf("t4_hi%0d", i), 0, i % 16, 0, 0, 0, 15);
        end

        // 5: step_en gating, HALT freeze, run=0 exit
        go_load();
        load(0, ins(4'h1, 4'd1)); load(1, ins(4'h2, 4'd1));
        load(2, ins(4'h2, 4'd1)); load(3, ins(4'hF, 4'd0));
        bus.run = 1'b1; bus.step_en = 1'b0;
        tick();
        bus.step_en = 1'b1; tick();
        bus.step_en = 1'b0; tick(); tick();
        bus.step_en = 1'b1; tick();
        expect_st("t5_two", 2, 2, 0, 0, 0, 15);
        tick(); tick(); tick();
        expect_st("t5_halt", 3, 3, 0, 0, 1, 15);
        bus.run = 1'b0;
        tick();
        expect_st("t5_load", 0, 0, 0, 0, 0, 15);

        // 6: async reset mid-program; program RAM survives
        load(0, ins(4'h1, 4'd6)); load(1, ins(4'hA, 4'd0));
        load(2, ins(4'h0, 4'd0)); load(3, ins(4'h7, 4'd0));
        bus.run = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        expect_st("t6_reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        out_q.push_back(6);
        tick(); tick(); tick();
        expect_st("t6_out", 6, 2, 0, 0, 0, 6);

        bus.run = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_q.size() != 0) begin
            failures++;
            $display("FAIL out_pulses: got %0d missing pulses expected 0", out_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
